arinc_429_tx: RTL and testbench
===============================

ARINC_429_TX -- requirements
Module: arinc_429_tx

Interface
REQ-001 SHALL have parameter HALF_BIT_DIV, default 2: clock cycles per half-bit (400 kHz clock gives a 100 kbit/s line); legal range 1..255.
REQ-002 SHALL have parameter GAP_BITS, default 4: null bit-times inserted after every word; legal range 4..15.
REQ-003 SHALL have parameter PARITY_EN, default 1: 1 = bit 31 replaced by generated odd parity; 0 = bit 31 sent as loaded.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_in, input, 32 bits: word to transmit; bit 0 is sent first.
REQ-007 SHALL have port load, input, 1 bit: write strobe, sampled on clock.
REQ-008 SHALL have port ready, output, 1 bit: holding register empty, load accepted.
REQ-009 SHALL have port busy, output, 1 bit: word or gap in progress.
REQ-010 SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of each word's gap.
REQ-011 SHALL have ports line_A and line_B, output, 1 bit each: registered RZ line drive.

Function
REQ-012 SHALL accept a word when load=1 and ready=1 at a rising edge; load with ready=0 is ignored, and the held word is unchanged.
REQ-013 SHALL store an accepted word in a one-entry holding register; ready=0 while it is occupied.
REQ-014 SHALL use FSM states IDLE, BIT_HI, BIT_LO and GAP.
REQ-015 IDLE with the holding register occupied SHALL move the word to the shift register, free the holding register, and go to BIT_HI with bit index 0.
REQ-016 An accept in IDLE SHALL produce line output for bit 0 starting at edge T+2, where T is the accepting edge (1 cycle to hold, 1 cycle to launch).
REQ-017 BIT_HI SHALL last HALF_BIT_DIV cycles: bit=1 drives A=1,B=0; bit=0 drives A=0,B=1.
REQ-018 BIT_LO SHALL last HALF_BIT_DIV cycles with A=0,B=0, then go to BIT_HI for the next bit, or to GAP after bit 31.
REQ-019 GAP SHALL last GAP_BITS*2*HALF_BIT_DIV cycles with A=0,B=0.
REQ-020 On the last GAP cycle the block SHALL pulse tx_done=1 for one cycle.
REQ-021 After GAP, if the holding register is occupied, the block SHALL go directly to BIT_HI with the held word (back-to-back, no IDLE cycle); otherwise it SHALL go to IDLE.
REQ-022 A load on the same edge that the holding register is emptied SHALL NOT be accepted, since ready was 0 at that edge.
REQ-023 With PARITY_EN=1, transmitted bit 31 SHALL be the XOR-NOT of data bits 0..30, fixed at the instant of launch.
REQ-024 line_A and line_B SHALL never both be 1.
REQ-025 busy=1 in BIT_HI, BIT_LO and GAP; busy=0 in IDLE.
REQ-026 Timing SHALL be counted by an 8-bit half-bit counter and a 5-bit bit index; the bit index wraps only through the GAP transition, never 31 to 0 inside a word.

Reset
REQ-027 While reset=0 the block SHALL immediately force state=IDLE, line_A=0, line_B=0, ready=1, busy=0, tx_done=0, all counters 0, and clear the holding register, independent of clock.
REQ-028 A reset mid-word SHALL abort the word without completing it or pulsing tx_done, and SHALL discard any held word.
REQ-029 After reset is released, the first accept SHALL follow REQ-016 timing exactly.

Verification (HALF_BIT_DIV=2, GAP_BITS=4, PARITY_EN=1)
REQ-030 Load 0x0000_0001 in IDLE -> bit 0 is A=1,B=0 for 2 cycles; bits 1..30 are A=0,B=1 pulses; bit 31 (parity) = 0, giving A=0,B=1; 16 null cycles; tx_done at cycle 144 after first line activity; ready returns to 1 one cycle after the accept.
REQ-031 Load 0x0000_0000 -> bit 31 sent as 1 (odd parity); every other bit is a B pulse; A is never high except bit 31.
REQ-032 Two loads: 0xA5A5_A5A5 and then 0x5A5A_5A5A during word 1 -> word 2 bit 0 starts on the cycle after word 1 tx_done; there are exactly 16 null cycles between words; a third load before word 2 launches is ignored.
REQ-033 Assert reset at bit 12 of a word -> lines go 0 within the same cycle; no tx_done; ready=1; the next load transmits cleanly.
REQ-034 Over all tests, a monitor checks: A&B never 1; each half-bit is exactly 2 cycles; a receiver model that shifts line_A on A|B rising edges reconstructs each loaded word, with parity applied.

Source files
------------

// File: rtl/arinc_429_tx.sv
// ARINC 429 word transmitter: one-entry holding register feeding an RZ bipolar line
// driver, with optional odd parity in bit 31 and a fixed null gap after every word.
module arinc_429_tx #(
    parameter int unsigned HALF_BIT_DIV = 2,
    parameter int unsigned GAP_BITS     = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        load,
    output logic        ready,
    output logic        busy,
    output logic        tx_done,
    output logic        line_A,
    output logic        line_B
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        GAP    = 2'd3
    } state_e;

    localparam logic [7:0] HALF_LAST = 8'(HALF_BIT_DIV - 1);
    localparam logic [4:0] GAP_LAST  = 5'(2 * GAP_BITS - 1);

    state_e      state_q, state_d;
    logic [7:0]  half_cnt_q, half_cnt_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        line_a_q, line_a_d;
    logic        line_b_q, line_b_d;
    logic        tx_done_q, tx_done_d;
    logic        half_last;
    logic        launch;

    // Parity is frozen into the shift register at launch, so later loads cannot disturb it.
    function automatic logic [31:0] launch_word(input logic [31:0] w);
        launch_word = w;
        if (PARITY_EN) begin
            launch_word[31] = ~^w[30:0];
        end
    endfunction

    assign half_last = (half_cnt_q == HALF_LAST);

    always_comb begin
        // NOTE: every _d signal gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        half_cnt_d  = half_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        line_a_d    = 1'b0;
        line_b_d    = 1'b0;
        tx_done_d   = 1'b0;
        launch      = 1'b0;

        if (load && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        if (state_q != IDLE) begin
            half_cnt_d = half_last ? 8'd0 : half_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                launch = hold_full_q;
            end
            BIT_HI: begin
                line_a_d = shift_q[0];
                line_b_d = ~shift_q[0];
                if (half_last) begin
                    state_d = BIT_LO;
                end
            end
            BIT_LO: begin
                if (half_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 5'd31) begin
                        state_d   = GAP;
                        bit_idx_d = 5'd0;
                    end else begin
                        state_d   = BIT_HI;
                        bit_idx_d = bit_idx_q + 5'd1;
                    end
                end
            end
            GAP: begin
                // In the gap the bit index counts null half-bits instead of data bits.
                if (half_last) begin
                    if (bit_idx_q == GAP_LAST) begin
                        tx_done_d = 1'b1;
                        bit_idx_d = 5'd0;
                        state_d   = IDLE;
                        launch    = hold_full_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            shift_d     = launch_word(hold_q);
            hold_full_d = 1'b0;
            bit_idx_d   = 5'd0;
            half_cnt_d  = 8'd0;
            state_d     = BIT_HI;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            half_cnt_q  <= 8'd0;
            bit_idx_q   <= 5'd0;
            shift_q     <= 32'd0;
            // NOTE: the holding register is reset too, so an aborted or pending word never resurfaces.
            hold_q      <= 32'd0;
            hold_full_q <= 1'b0;
            line_a_q    <= 1'b0;
            line_b_q    <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            line_a_q    <= line_a_d;
            line_b_q    <= line_b_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign ready   = ~hold_full_q;
    assign busy    = (state_q != IDLE);
    assign tx_done = tx_done_q;
    assign line_A  = line_a_q;
    assign line_B  = line_b_q;

endmodule

// File: tb/tb_arinc_429_tx.sv
// Bench for arinc_429_tx: a timeline model of the expected line, a receiver that
// rebuilds words from the line, and directed tests with hand-computed values.
module tb_arinc_429_tx;

    localparam int unsigned HALF = 2;
    localparam int unsigned GAP  = 4;
    localparam bit          PAR  = 1'b1;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic        load    = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        ready, busy, tx_done, line_A, line_B;

    int n_cmp  = 0;
    int n_fail = 0;

    arinc_429_tx #(
        .HALF_BIT_DIV(HALF),
        .GAP_BITS    (GAP),
        .PARITY_EN   (PAR)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data_in(data_in),
        .load   (load),
        .ready  (ready),
        .busy   (busy),
        .tx_done(tx_done),
        .line_A (line_A),
        .line_B (line_B)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word as it must appear on the wire: odd parity over all 32 bits.
    function automatic logic [31:0] on_wire(input logic [31:0] w);
        int ones;
        ones    = 0;
        on_wire = w;
        for (int i = 0; i < 31; i++) begin
            if (w[i]) ones++;
        end
        if (PAR) on_wire[31] = ((ones % 2) == 0);
    endfunction

    // ---------------- timeline model ----------------
    typedef struct {
        bit a;
        bit b;
        bit done;
    } samp_t;

    samp_t       exp_q[$];
    samp_t       cur;
    bit          m_full   = 1'b0;
    bit          m_accept = 1'b0;
    logic [31:0] m_word   = 32'd0;
    logic [31:0] exp_words[$];

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < int'(HALF); k++) exp_q.push_back('{a: w[i], b: !w[i], done: 1'b0});
            for (int k = 0; k < int'(HALF); k++) exp_q.push_back('{a: 1'b0, b: 1'b0, done: 1'b0});
        end
        for (int g = 0; g < int'(2 * GAP * HALF); g++)
            exp_q.push_back('{a: 1'b0, b: 1'b0, done: (g == int'(2 * GAP * HALF) - 1)});
    endtask

    initial begin
        cur = '{a: 1'b0, b: 1'b0, done: 1'b0};
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                exp_q.delete();
                exp_words.delete();
                m_full = 1'b0;
                cur    = '{a: 1'b0, b: 1'b0, done: 1'b0};
            end else begin
                m_accept = load && !m_full;
                cur      = '{a: 1'b0, b: 1'b0, done: 1'b0};
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                // A held word starts its line output right after the previous timeline ends.
                if (exp_q.size() == 0 && m_full) begin
                    push_word(on_wire(m_word));
                    m_full = 1'b0;
                end
                if (m_accept) begin
                    m_word = data_in;
                    m_full = 1'b1;
                    exp_words.push_back(on_wire(data_in));
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clock);
        check("line_A", line_A, cur.a);
        check("line_B", line_B, cur.b);
        check("tx_done", tx_done, cur.done);
        check("ready", ready, !m_full);
        check("busy", busy, exp_q.size() > 0);
        check("a_and_b", line_A & line_B, 1'b0);
    end

    // ---------------- receiver monitor ----------------
    logic [31:0] rx     = 32'd0;
    int          rx_n   = 0;
    int          rx_idx = 0;
    int          run    = 0;
    int          a_high = 0;
    bit          prev   = 1'b0;
    logic [31:0] rx_log[$];

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            rx_n   = 0;
            rx_idx = 0;
            run    = 0;
            prev   = 1'b0;
        end else begin
            if ((line_A | line_B) && !prev) begin
                rx = {line_A, rx[31:1]};
                rx_n++;
            end
            if (line_A | line_B) begin
                run++;
            end else if (prev) begin
                check("half_bit_width", run, HALF);
                run = 0;
            end
            if (line_A) a_high++;
            if (rx_n == 32) begin
                if (rx_idx < exp_words.size()) check("rx_word", rx, exp_words[rx_idx]);
                else check("rx_unexpected_word", rx_idx, exp_words.size());
                rx_log.push_back(rx);
                rx_idx++;
                rx_n = 0;
            end
            prev = line_A | line_B;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input logic [31:0] w);
        @(posedge clock);
        #2;
        load    = 1'b1;
        data_in = w;
        @(posedge clock);
        #2;
        load = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (ready && !busy) break;
        end
        check(nm, ready && !busy, 1'b1);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (tx_done) break;
        end
        check(nm, tx_done, 1'b1);
    endtask

    task automatic wait_active(input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (line_A | line_B) break;
        end
        check(nm, line_A | line_B, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    int n0;
    int cyc;
    int a0;

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_lines", {line_A, line_B}, 2'b00);
        check("rst_tx_done", tx_done, 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        // Single word 0x00000001: parity bit 0, tx_done on the 144th line cycle
        n0 = rx_log.size();
        do_load(32'h0000_0001);
        check("t1_ready_after_accept", ready, 1'b0);
        @(posedge clock);
        #2;
        check("t1_ready_next_cycle", ready, 1'b1);
        wait_active("t1_first_activity");
        check("t1_bit0_lines", {line_A, line_B}, 2'b10);
        cyc = 1;
        for (int i = 0; i < 300 && !tx_done; i++) begin
            @(negedge clock);
            cyc++;
        end
        check("t1_tx_done_cycle", cyc, 144);
        wait_idle("t1_idle");
        check("t1_rx_count", rx_log.size(), n0 + 1);
        check("t1_rx_word", rx_log[$], 32'h0000_0001);

        // All-zero word: only bit 31 drives A
        a0 = a_high;
        do_load(32'h0000_0000);
        wait_idle("t2_idle");
        check("t2_rx_word", rx_log[$], 32'h8000_0000);
        check("t2_a_high_cycles", a_high - a0, 2);

        // Load held across the edge that empties the holding register is ignored
        n0 = rx_log.size();
        @(posedge clock);
        #2;
        load    = 1'b1;
        data_in = 32'h1234_5678;
        @(posedge clock);
        #2;
        data_in = 32'hFFFF_FFFF;
        @(posedge clock);
        #2;
        load = 1'b0;
        wait_idle("t3_idle");
        repeat (5) @(negedge clock);
        check("t3_no_second_word", busy, 1'b0);
        check("t3_rx_count", rx_log.size(), n0 + 1);
        check("t3_rx_word", rx_log[$], 32'h1234_5678);

        // Back-to-back words; third load while holding register is full is dropped
        n0 = rx_log.size();
        do_load(32'hA5A5_A5A5);
        repeat (20) @(posedge clock);
        do_load(32'h5A5A_5A5A);
        repeat (5) @(posedge clock);
        do_load(32'hFFFF_FFFF);
        wait_done("t4_word1_done");
        @(negedge clock);
        check("t4_word2_bit0_lines", {line_A, line_B}, 2'b01);
        wait_idle("t4_idle");
        check("t4_rx_count", rx_log.size(), n0 + 2);
        check("t4_rx_word1", rx_log[n0], 32'h25A5_A5A5);
        check("t4_rx_word2", rx_log[n0 + 1], 32'hDA5A_5A5A);

        // Reset at bit 12 aborts the word and drops the held word
        n0 = rx_log.size();
        do_load(32'hFFFF_0000);
        do_load(32'h1111_1111);
        for (int i = 0; i < 200 && rx_n != 13; i++) @(negedge clock);
        check("t5_reached_bit12", rx_n, 13);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("t5_lines_async", {line_A, line_B}, 2'b00);
        check("t5_ready_async", ready, 1'b1);
        check("t5_busy_async", busy, 1'b0);
        check("t5_tx_done_async", tx_done, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("t5_held_discarded", busy, 1'b0);
        check("t5_no_partial_word", rx_log.size(), n0);
        do_load(32'h0F0F_0F0F);
        wait_active("t5_after_reset_activity");
        wait_idle("t5_idle");
        check("t5_rx_count", rx_log.size(), n0 + 1);
        check("t5_rx_word", rx_log[$], 32'h8F0F_0F0F);

        repeat (5) @(negedge clock);
        check("all_words_received", rx_idx, exp_words.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
